// File: rtl/vga_board_renderer.sv
// vga_board_renderer: VGA timing generator that draws a Tetris board of
// 2-bit colour-coded cells plus a 4x4-mask falling piece, RGB332 output.
// Board and piece are snapshotted once per frame, so a frame never tears.
// rgb/hsync/vsync lag the pixel counters by two clocks and stay aligned.
// Optional build macro: VGA_GRID_LINES_EN draws grey grid lines on cell edges.
module vga_board_renderer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned BOARD_W  = 10,
    parameter int unsigned BOARD_H  = 20,
    parameter int unsigned CELL     = 16,
    parameter int unsigned BOARD_X0 = 240,
    parameter int unsigned BOARD_Y0 = 80
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [2*BOARD_W*BOARD_H-1:0]   board,
    input  logic [7:0]                     piece_x,
    input  logic [7:0]                     piece_y,
    input  logic [15:0]                    piece_mask,
    input  logic [7:0]                     piece_rgb,
    output logic [7:0]                     rgb,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW       = $clog2(H_TOTAL);
    localparam int unsigned YW       = $clog2(V_TOTAL);
    localparam int unsigned SW       = $clog2(CELL);
    localparam int unsigned BRD_BITS = 2 * BOARD_W * BOARD_H;

    // Timing and cell-tracking state
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [7:0]    cx_q, cx_d, cy_q, cy_d;
    logic          frame_start_q;

    // Per-frame shadow copy of the game-logic inputs
    logic [BRD_BITS-1:0] board_sh_q;
    logic [7:0]          px_sh_q, py_sh_q, prgb_sh_q;
    logic [15:0]         mask_sh_q;

    // Pipeline stage 1 and stage 2 registers
    logic [1:0] code_q;
    logic       hit_q, inreg_q, hs1_q, vs1_q;
    logic [7:0] rgb_q;
    logic       hsync_q, vsync_q;
`ifdef VGA_GRID_LINES_EN
    logic       grid_q;
    logic       grid_c;
`endif

    // Stage-1 lookup signals
    logic        in_region_c, hs_raw_c, vs_raw_c, hit_c;
    logic [31:0] cell_idx_c, cell_sel_c;
    logic [7:0]  dx_c, dy_c;
    logic [1:0]  code_c;
    logic [7:0]  rgb_d;

    // Next pixel position and divider-free cell/sub-cell tracking
    always_comb begin
        x_d  = x_q + XW'(1);
        y_d  = y_q;
        sx_d = sx_q + SW'(1);
        cx_d = cx_q;
        sy_d = sy_q;
        cy_d = cy_q;
        if (x_q == XW'(H_TOTAL - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(V_TOTAL - 1)) ? '0 : y_q + YW'(1);
        end
        if (x_d == XW'(BOARD_X0)) begin
            sx_d = '0;
            cx_d = '0;
        end else if (sx_q == SW'(CELL - 1)) begin
            sx_d = '0;
            cx_d = cx_q + 8'd1;
        end
        if (x_q == XW'(H_TOTAL - 1)) begin
            if (y_d == YW'(BOARD_Y0)) begin
                sy_d = '0;
                cy_d = '0;
            end else if (sy_q == SW'(CELL - 1)) begin
                sy_d = '0;
                cy_d = cy_q + 8'd1;
            end else begin
                sy_d = sy_q + SW'(1);
            end
        end
    end

    // Region test, raw syncs, board cell lookup and piece-mask hit for the current pixel
    always_comb begin
        in_region_c = (x_q >= XW'(BOARD_X0)) && (x_q < XW'(BOARD_X0 + BOARD_W * CELL)) &&
                      (y_q >= YW'(BOARD_Y0)) && (y_q < YW'(BOARD_Y0 + BOARD_H * CELL)) &&
                      (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
        hs_raw_c    = !((x_q >= XW'(H_ACTIVE + H_FP)) && (x_q < XW'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw_c    = !((y_q >= YW'(V_ACTIVE + V_FP)) && (y_q < YW'(V_ACTIVE + V_FP + V_SYNC)));
        cell_idx_c  = 32'(cy_q) * 32'(BOARD_W) + 32'(cx_q);
        cell_sel_c  = in_region_c ? cell_idx_c : 32'd0;
        code_c      = board_sh_q[2 * cell_sel_c +: 2];
        dx_c        = cx_q - px_sh_q;
        dy_c        = cy_q - py_sh_q;
        hit_c       = (dx_c < 8'd4) && (dy_c < 8'd4) && mask_sh_q[{dy_c[1:0], dx_c[1:0]}];
`ifdef VGA_GRID_LINES_EN
        grid_c      = (sx_q == '0) || (sy_q == '0);
`endif
    end

    // Stage-2 colour select: piece over grid over board palette, black outside
    always_comb begin
        rgb_d = 8'h00;
        if (inreg_q) begin
            case (code_q)
                2'd0:    rgb_d = 8'hF0;
                2'd1:    rgb_d = 8'h03;
                2'd2:    rgb_d = 8'h1C;
                default: rgb_d = 8'hE0;
            endcase
`ifdef VGA_GRID_LINES_EN
            if (grid_q) rgb_d = 8'h49;
`endif
            if (hit_q) rgb_d = prgb_sh_q;
        end
    end

    // Counters, frame snapshot and two-stage output pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            sx_q          <= '0;
            cx_q          <= '0;
            sy_q          <= '0;
            cy_q          <= '0;
            frame_start_q <= 1'b0;
            board_sh_q    <= '0;
            px_sh_q       <= '0;
            py_sh_q       <= '0;
            mask_sh_q     <= '0;
            prgb_sh_q     <= '0;
            code_q        <= '0;
            hit_q         <= 1'b0;
            inreg_q       <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            rgb_q         <= 8'h00;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
`ifdef VGA_GRID_LINES_EN
            grid_q        <= 1'b0;
`endif
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            sx_q          <= sx_d;
            cx_q          <= cx_d;
            sy_q          <= sy_d;
            cy_q          <= cy_d;
            // high exactly while the counters sit at (0, V_ACTIVE)
            frame_start_q <= (x_d == '0) && (y_d == YW'(V_ACTIVE));
            if (frame_start_q) begin
                board_sh_q <= board;
                px_sh_q    <= piece_x;
                py_sh_q    <= piece_y;
                mask_sh_q  <= piece_mask;
                prgb_sh_q  <= piece_rgb;
            end
            code_q        <= code_c;
            hit_q         <= hit_c;
            inreg_q       <= in_region_c;
            hs1_q         <= hs_raw_c;
            vs1_q         <= vs_raw_c;
            rgb_q         <= rgb_d;
            hsync_q       <= hs1_q;
            vsync_q       <= vs1_q;
`ifdef VGA_GRID_LINES_EN
            grid_q        <= grid_c;
`endif
        end
    end

    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_board_renderer.sv
// Bench for vga_board_renderer: a reduced-size instance checked pixel by pixel
// against a scoreboard, plus a default-size instance for absolute sync timing.
module tb_vga_board_renderer;

    localparam int HA = 48, HF = 4, HS = 8, HB = 4;
    localparam int VA = 40, VF = 2, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int BWD = 10, BHT = 8, CL = 2, X0 = 8, Y0 = 4;

    logic                   clk;
    logic                   rst_n;
    logic [2*BWD*BHT-1:0]   board;
    logic [7:0]             piece_x, piece_y, piece_rgb;
    logic [15:0]            piece_mask;
    logic [7:0]             rgb;
    logic                   hsync, vsync, frame_start;

    logic [399:0]           board_def;
    logic [7:0]             rgb_def;
    logic                   hs_def, vs_def, fs_def;

    vga_board_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BOARD_W(BWD), .BOARD_H(BHT), .CELL(CL), .BOARD_X0(X0), .BOARD_Y0(Y0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .board(board),
        .piece_x(piece_x), .piece_y(piece_y), .piece_mask(piece_mask), .piece_rgb(piece_rgb),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    vga_board_renderer u_dut_def (
        .clk(clk), .rst_n(rst_n), .board(board_def),
        .piece_x(8'd0), .piece_y(8'd0), .piece_mask(16'd0), .piece_rgb(8'd0),
        .rgb(rgb_def), .hsync(hs_def), .vsync(vs_def), .frame_start(fs_def)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [9:0] v;
    } exp_t;

    exp_t               sb_q[$];
    exp_t               sb_e;
    logic               fs_exp;
    logic [2*BWD*BHT-1:0] m_board;
    logic [7:0]         m_px, m_py, m_rgb;
    logic [15:0]        m_mask;
    int                 bx = 0, by = 0;
    bit                 armed = 0;
    int                 low_cnt = 0;

    // Reference pixel: {rgb, hsync, vsync} for counter position (x, y)
    function automatic logic [9:0] model_pix(input int x, input int y);
        logic [7:0] col;
        logic       hs, vs;
        logic [1:0] code;
        int         cx, cy, dx, dy;
        hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        col = 8'h00;
        if (x >= X0 && x < X0 + BWD * CL && y >= Y0 && y < Y0 + BHT * CL) begin
            cx   = (x - X0) / CL;
            cy   = (y - Y0) / CL;
            code = m_board[2 * (cy * BWD + cx) +: 2];
            case (code)
                2'd0:    col = 8'hF0;
                2'd1:    col = 8'h03;
                2'd2:    col = 8'h1C;
                default: col = 8'hE0;
            endcase
`ifdef VGA_GRID_LINES_EN
            if ((x - X0) % CL == 0 || (y - Y0) % CL == 0) col = 8'h49;
`endif
            dx = (cx - int'(m_px)) & 255;
            dy = (cy - int'(m_py)) & 255;
            if (dx < 4 && dy < 4 && m_mask[dy * 4 + dx]) col = m_rgb;
        end
        return {col, hs, vs};
    endfunction

    // Scoreboard: push expected pixel each cycle, pop the one the 2-stage pipe emits now
    always @(negedge clk) begin
        if (!rst_n && low_cnt > 0) begin
            check_val("reset_out", {rgb, hsync, vsync, frame_start}, {8'h00, 1'b1, 1'b1, 1'b0});
            bx      = 0;
            by      = 0;
            m_board = '0;
            m_px    = '0;
            m_py    = '0;
            m_mask  = '0;
            m_rgb   = '0;
            sb_q.delete();
            sb_q.push_back('{-1, -1, 10'h003});
            sb_q.push_back('{-1, -1, 10'h003});
            armed   = 1;
        end else if (armed) begin
            sb_q.push_back('{bx, by, model_pix(bx, by)});
            sb_e   = sb_q.pop_front();
            fs_exp = (bx == 0) && (by == VA);
            check_val($sformatf("pix(%0d,%0d)", sb_e.x, sb_e.y),
                      {rgb, hsync, vsync, frame_start}, {sb_e.v, fs_exp});
            if (fs_exp) begin
                m_board = board;
                m_px    = piece_x;
                m_py    = piece_y;
                m_mask  = piece_mask;
                m_rgb   = piece_rgb;
            end
            bx++;
            if (bx == HT) begin
                bx = 0;
                by++;
                if (by == VT) by = 0;
            end
        end
        low_cnt = rst_n ? 0 : low_cnt + 1;
    end

    // Wait (bounded) until the counters reach the start of line yy
    task automatic wait_line(input int yy);
        bit found;
        found = 0;
        for (int k = 0; k < 2 * HT * VT && !found; k++) begin
            @(posedge clk);
            if (bx == 0 && by == yy) found = 1;
        end
        check_val($sformatf("reach_line%0d", yy), 32'(found), 32'd1);
    endtask

    // Default-size instance: absolute hsync timing after the first reset release
    int  fall1 = -1, rise1 = -1, fall2 = -1;
    bit  hs_prev = 1;
    initial begin
        @(posedge rst_n);
        for (int k = 1; k <= 1500; k++) begin
            @(posedge clk);
            #1;
            if (hs_prev && !hs_def) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!hs_prev && hs_def && rise1 < 0) rise1 = k;
            hs_prev = hs_def;
        end
        check_val("def_hs_first_fall", fall1, 658);
        check_val("def_hs_low_width", rise1 - fall1, 96);
        check_val("def_hs_period", fall2 - fall1, 800);
        check_val("def_idle_outs", {rgb_def, vs_def, fs_def}, {8'h00, 1'b1, 1'b0});
    end

    // Stimulus
    initial begin
        rst_n      = 1'b0;
        board_def  = '0;
        board      = '0;
        board[1:0] = 2'b01;
        board[2*(3*BWD+5) +: 2] = 2'b10;
        board[2*(7*BWD+9) +: 2] = 2'b11;
        piece_x    = 8'd0;
        piece_y    = 8'd0;
        piece_mask = 16'h0000;
        piece_rgb  = 8'h00;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        // frame 1 renders the zero snapshot; frame 2 shows the initial board
        wait_line(VA);
        wait_line(10);
        // mid-frame change: invisible until the frame after the next frame_start
        #1;
        board[1:0] = 2'b11;
        board[2*(0*BWD+9) +: 2] = 2'b10;
        piece_x    = 8'd3;
        piece_y    = 8'd5;
        piece_mask = 16'h0033;
        piece_rgb  = 8'hFF;

        wait_line(10);
        #1;
        piece_x    = 8'd9;
        piece_y    = 8'd2;
        piece_mask = 16'h000F;
        piece_rgb  = 8'h5A;

        wait_line(10);
        #1;
        piece_x    = 8'd8;
        piece_y    = 8'd6;
        piece_mask = 16'hFFFF;
        piece_rgb  = 8'hAB;

        // mid-frame reset
        wait_line(20);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        wait_line(VA);
        wait_line(VA);
        wait_line(VT - 1);
        repeat (HT + 4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_board_renderer.md
Name: vga_board_renderer

Overview:
- Parametrised successor to the single-piece VGA display: generates VGA timing and renders a Tetris board of 2-bit colour-coded cells plus a 4x4-mask falling piece, RGB332 output.
- Sits between game logic and the VGA pins.
- Adds registered pipelined outputs with aligned syncs, division-free cell tracking, and a per-frame shadow snapshot of board and piece (no tearing).
- Drives a frame_start pulse back to game logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and pulse widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and pulse widths in lines
- BOARD_W, 10, board width in cells
- BOARD_H, 20, board height in cells
- CELL, 16, cell edge in pixels (>=2)
- BOARD_X0, 240, first board pixel column
- BOARD_Y0, 80, first board pixel row

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- board  in  2*BOARD_W*BOARD_H  cell codes; cell (cx,cy) at bits [2*(cy*BOARD_W+cx) +: 2]
- piece_x  in  8  piece origin column (cells)
- piece_y  in  8  piece origin row (cells)
- piece_mask  in  16  4x4 shape; bit r*4+c marks cell (piece_x+c, piece_y+r)
- piece_rgb  in  8  piece colour, RGB332
- rgb  out  8  pixel colour, RGB332
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset state:
  - pixel counters = 0; shadow registers = 0.
  - rgb = 8'h00, hsync = 1, vsync = 1, frame_start = 0.
  - Reset asserted mid-frame: all outputs take reset values on the next edge; timing restarts at (0,0) one cycle after release.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise.
  - x wraps at H_TOTAL-1 to 0, at which point y increments; y wraps at V_TOTAL-1. Line period is exactly H_TOTAL clocks; frame period is exactly H_TOTAL*V_TOTAL clocks.
- Sync timing (pre-pipeline):
  - hsync low for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync low for y in the equivalent vertical range.
- Cell tracking: no divider.
  - Sub-cell counter sx and cell column cx both clear at x==BOARD_X0; sx counts 0..CELL-1, and cx increments when sx wraps.
  - sy/cy do the same per line, clearing at y==BOARD_Y0.
- In-board region:
  - BOARD_X0 <= x < BOARD_X0+BOARD_W*CELL, and the same test vertically. Both start bounds are inclusive.
  - Outside the region, or during blanking: colour 8'h00.
- Cell palette:
  - code 0 = 8'hF0 (orange, empty)
  - code 1 = 8'h03 (blue)
  - code 2 = 8'h1C (green)
  - code 3 = 8'hE0 (red)
- Piece overlay:
  - A pixel is a piece pixel if (cx-piece_x) and (cy-piece_y) both lie in 0..3 (8-bit unsigned subtraction, no wrap hit) and the corresponding mask bit = 1.
  - Piece colour overrides the board colour.
  - Piece cells outside the board are clipped silently.
- Snapshot:
  - board, piece_x, piece_y, piece_mask, and piece_rgb are latched into shadow registers on the cycle x==0 && y==V_ACTIVE.
  - frame_start pulses high during that same cycle.
  - Rendering uses only the shadow registers, so input changes mid-frame are invisible until the next frame.
- Pipeline:
  - Stage 1 registers the cell lookup, mask hit, in-region flag and raw syncs. Stage 2 registers rgb, hsync and vsync.
  - All three outputs therefore lag the counters by exactly 2 cycles and stay mutually aligned.
  - frame_start is not delayed.

Optional Feature:
- Macro: VGA_GRID_LINES_EN.
- Defined: in-board pixels with sx==0 or sy==0 render 8'h49 (grey grid line). This takes priority over the board colour, but not over the piece colour.
- Undefined: no grid; the logic is absent.

Test Plan:
- Reset release, default params -> hsync low pulse of 96 clocks, period 800 clocks; vsync low for 2 lines, frame period 420000 clocks; first falling edge of hsync at clock 658 after release (656 + 2 latency).
- board bit pair for cell (0,0) = 2'b01, rest 0, mask 0 -> pixels (240..255, 80..95) = 8'h03; pixel (256,80) = 8'hF0; pixel (239,80) = 8'h00.
- piece_x=3, piece_y=5, mask=16'h0033 (2x2 square), piece_rgb=8'hFF -> cells (3..4, 5..6) render 8'hFF, i.e. pixel rectangle x 288..319, y 160..191.
- Change board while y==100 -> frame unchanged; change appears the frame after the next frame_start; frame_start is exactly 1 cycle wide, once per frame.
- piece_x=9, mask=16'h000F -> only cell 9 of that row drawn; no wrap into the next row.
- Assert rst_n=0 for 3 cycles at y=200 -> outputs take reset values next edge; next hsync pulse starts 658 clocks after release. With VGA_GRID_LINES_EN defined, pixel (256,80) = 8'h49.
